// File: rtl/gbvga_pkg.sv
// Constants and types shared by the Game Boy VGA capture/debug blocks.
package gbvga_pkg;

  localparam int unsigned CLK_HZ_16M         = 16_000_000;
  // Measured board crystal rate; the nominal CLK_HZ_16M runs slightly fast.
  localparam int unsigned CLOCKS_PER_SEC_CAL = 15_998_100;
  localparam int unsigned WIN_W              = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ALIGN   = 2'd1,
    MEASURE = 2'd2
  } fps_state_t;

  function automatic logic [WIN_W-1:0] win_terminal(input int unsigned clocks);
    return WIN_W'(clocks - 1);
  endfunction

endpackage

// File: rtl/fps_meter_if.sv
// Result channel of the frame-rate meter: value/overflow qualified by valid, accepted by ready.
interface fps_meter_if #(
  parameter int COUNT_W = 8
) ();

  logic [COUNT_W-1:0] FPS_VALUE;
  logic               FPS_OVF;
  logic               FPS_VALID;
  logic               FPS_READY;
  logic               FPS_DROP;

  modport master (
    output FPS_VALUE,
    output FPS_OVF,
    output FPS_VALID,
    output FPS_DROP,
    input  FPS_READY
  );

  modport slave (
    input  FPS_VALUE,
    input  FPS_OVF,
    input  FPS_VALID,
    input  FPS_DROP,
    output FPS_READY
  );

endinterface

// File: rtl/pulse_sync.sv
// Multi-stage synchroniser plus registered rising-edge detector for asynchronous strobes.
// edge_o is one cycle wide, SYNC_STAGES+1 cycles after async_i rises; clr_i wipes all history.
module pulse_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic async_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    prev_d = sync_q[SYNC_STAGES-1];
    edge_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    if (clr_i) begin
      sync_d = '0;
      prev_d = 1'b0;
      edge_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      edge_q <= edge_d;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/fps_meter.sv
// Frame-rate meter: counts FRAME_PULSE rising edges per CLOCKS_PER_SEC window, windows aligned to a frame.
// Result appears the cycle after a window's last cycle; an unaccepted result is overwritten with a FPS_DROP pulse.
module fps_meter
  import gbvga_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_SEC = CLOCKS_PER_SEC_CAL,
  parameter int unsigned COUNT_W        = 8,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic        CLK16MHz,
  input  logic        RST_N,
  input  logic        ENABLE,
  input  logic        FRAME_PULSE,
  output logic        BLINK_PIN,
  fps_meter_if.master fps
);

  localparam logic [WIN_W-1:0]   WIN_TERM = win_terminal(CLOCKS_PER_SEC);
  localparam logic [COUNT_W-1:0] CNT_MAX  = '1;

  fps_state_t         state_q, state_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [COUNT_W-1:0] value_q, value_d;
  logic               res_ovf_q, res_ovf_d;
  logic               valid_q, valid_d;
  logic               drop_q, drop_d;
  logic               blink_q, blink_d;

  logic               frame_edge;
  logic               at_term;
  logic               clr_cnt, align_ld, count_en, latch;
  logic [COUNT_W-1:0] cnt_inc;
  logic               ovf_inc;

  // Edge history is dropped whenever measurement is disabled.
  pulse_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_frame_sync (
    .clk     (CLK16MHz),
    .rst_n   (RST_N),
    .clr_i   (!ENABLE),
    .async_i (FRAME_PULSE),
    .edge_o  (frame_edge)
  );

  always_ff @(posedge CLK16MHz or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!ENABLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ALIGN;
        ALIGN:   if (frame_edge) state_d = MEASURE;
        MEASURE: state_d = MEASURE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign at_term = (win_q == WIN_TERM);

  always_comb begin
    clr_cnt  = 1'b0;
    align_ld = 1'b0;
    count_en = 1'b0;
    latch    = 1'b0;
    if (!ENABLE) begin
      clr_cnt = 1'b1;
    end else begin
      case (state_q)
        IDLE:    clr_cnt  = 1'b1;
        ALIGN:   align_ld = frame_edge;
        MEASURE: begin
          latch    = at_term;
          clr_cnt  = at_term;
          count_en = !at_term;
        end
        default: clr_cnt = 1'b1;
      endcase
    end
  end

  // Saturating count including this cycle's edge; also what closes a window.
  assign cnt_inc = (frame_edge && (cnt_q != CNT_MAX)) ? cnt_q + COUNT_W'(1) : cnt_q;
  assign ovf_inc = ovf_q | (frame_edge & (cnt_q == CNT_MAX));

  always_comb begin
    win_d = win_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_cnt) begin
      win_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (align_ld) begin
      win_d = '0;
      cnt_d = COUNT_W'(1);
      ovf_d = 1'b0;
    end else if (count_en) begin
      win_d = win_q + WIN_W'(1);
      cnt_d = cnt_inc;
      ovf_d = ovf_inc;
    end
  end

  always_comb begin
    value_d   = value_q;
    res_ovf_d = res_ovf_q;
    blink_d   = blink_q;
    drop_d    = 1'b0;
    valid_d   = valid_q && !fps.FPS_READY;
    if (latch) begin
      value_d   = cnt_inc;
      res_ovf_d = ovf_inc;
      blink_d   = ~blink_q;
      valid_d   = 1'b1;
      drop_d    = valid_q && !fps.FPS_READY;
    end
    if (!ENABLE) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK16MHz or negedge RST_N) begin
    if (!RST_N) begin
      win_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      value_q   <= '0;
      res_ovf_q <= 1'b0;
      valid_q   <= 1'b0;
      drop_q    <= 1'b0;
      blink_q   <= 1'b0;
    end else begin
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      value_q   <= value_d;
      res_ovf_q <= res_ovf_d;
      valid_q   <= valid_d;
      drop_q    <= drop_d;
      blink_q   <= blink_d;
    end
  end

  assign fps.FPS_VALUE = value_q;
  assign fps.FPS_OVF   = res_ovf_q;
  assign fps.FPS_VALID = valid_q;
  assign fps.FPS_DROP  = drop_q;
  assign BLINK_PIN     = blink_q;

endmodule

// File: tb/tb_fps_meter.sv
// Directed bench for fps_meter: 100-cycle windows, an 8-bit and a 4-bit counter instance side by side.
module tb_fps_meter;
  import gbvga_pkg::*;

  localparam int CPS = 100;

  logic clk = 1'b0;
  logic RST_N;
  logic ENABLE;
  logic FRAME_PULSE;
  logic blink;
  logic blink_s;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int sched[$];

  fps_meter_if #(.COUNT_W(8)) fps ();
  fps_meter_if #(.COUNT_W(4)) fps_s ();

  fps_meter #(
    .CLOCKS_PER_SEC (CPS),
    .COUNT_W        (8),
    .SYNC_STAGES    (2)
  ) dut (
    .CLK16MHz    (clk),
    .RST_N       (RST_N),
    .ENABLE      (ENABLE),
    .FRAME_PULSE (FRAME_PULSE),
    .BLINK_PIN   (blink),
    .fps         (fps)
  );

  fps_meter #(
    .CLOCKS_PER_SEC (CPS),
    .COUNT_W        (4),
    .SYNC_STAGES    (2)
  ) dut_sat (
    .CLK16MHz    (clk),
    .RST_N       (RST_N),
    .ENABLE      (ENABLE),
    .FRAME_PULSE (FRAME_PULSE),
    .BLINK_PIN   (blink_s),
    .fps         (fps_s)
  );

  always #5 clk = ~clk;

  function automatic bit sched_has(input int c);
    foreach (sched[i]) if (sched[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  // sched holds the cycles on which FRAME_EDGE must appear: the pulse rises 3 cycles earlier, high for 2.
  initial begin
    FRAME_PULSE = 1'b0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      FRAME_PULSE = sched_has(cyc + 3) || sched_has(cyc + 2);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d (checks=%0d errors=%0d)", cyc, checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset();
    RST_N           = 1'b0;
    ENABLE          = 1'b0;
    fps.FPS_READY   = 1'b1;
    fps_s.FPS_READY = 1'b1;
    sched.delete();
    repeat (3) @(negedge clk);
    RST_N = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int c, e0, nvld;
    do_reset();
    checks++;
    if ({fps.FPS_VALUE, fps.FPS_OVF, fps.FPS_VALID, fps.FPS_DROP, blink} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got value=%0d ovf=%b valid=%b drop=%b blink=%b want all 0",
               fps.FPS_VALUE, fps.FPS_OVF, fps.FPS_VALID, fps.FPS_DROP, blink);
    end
    fps.FPS_READY = 1'b0;
    c = cyc; ENABLE = 1'b1; e0 = c + 5;
    for (int i = 0; i <= 13; i++) sched.push_back(e0 + 10 * i);
    wait_cyc(e0 + 101);
    checks++;
    if (fps.FPS_VALID !== 1'b1 || blink !== 1'b1) begin
      errors++;
      $display("FAIL reset_prewindow: got valid=%b blink=%b want valid=1 blink=1", fps.FPS_VALID, blink);
    end
    wait_cyc(e0 + 125);
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if (fps.FPS_VALUE !== 8'd0 || fps.FPS_OVF !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_value: got value=%0d ovf=%b want 0/0", fps.FPS_VALUE, fps.FPS_OVF);
    end
    checks++;
    if (fps.FPS_VALID !== 1'b0 || fps.FPS_DROP !== 1'b0 || blink !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_ctrl: got valid=%b drop=%b blink=%b want 0", fps.FPS_VALID, fps.FPS_DROP, blink);
    end
    @(negedge clk);
    sched.delete();
    ENABLE = 1'b0;
    RST_N  = 1'b1;
    c = cyc;
    for (int i = 1; i <= 99; i++) sched.push_back(c + 10 * i);
    nvld = 0;
    repeat (1000) begin
      @(negedge clk);
      if (fps.FPS_VALID === 1'b1) nvld++;
    end
    checks++;
    if (nvld != 0) begin
      errors++;
      $display("FAIL idle_no_valid: got %0d valid cycles want 0", nvld);
    end
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL idle_state: got %0d want %0d", dut.state_q, IDLE);
    end
  endtask

  task automatic test_steady();
    int c, e0;
    do_reset();
    c = cyc; ENABLE = 1'b1; e0 = c + 5;
    for (int i = 0; i <= 40; i++) sched.push_back(e0 + 10 * i);
    // Window 1 also holds the aligning edge; later windows are the steady 10.
    for (int k = 2; k <= 4; k++) begin
      wait_cyc(e0 + 100 * k + 1);
      checks++;
      if (fps.FPS_VALID !== 1'b1 || fps.FPS_VALUE !== 8'd10 || fps.FPS_OVF !== 1'b0) begin
        errors++;
        $display("FAIL steady_w%0d: got valid=%b value=%0d ovf=%b want 1/10/0",
                 k, fps.FPS_VALID, fps.FPS_VALUE, fps.FPS_OVF);
      end
      checks++;
      if (blink !== 1'(k % 2)) begin
        errors++;
        $display("FAIL steady_blink_w%0d: got %b want %0d", k, blink, k % 2);
      end
    end
    wait_cyc(e0 + 402);
    checks++;
    if (fps.FPS_VALID !== 1'b0) begin
      errors++;
      $display("FAIL steady_valid_drop: got %b want 0", fps.FPS_VALID);
    end
  endtask

  task automatic test_boundary();
    int c, e0;
    int exp_val[4] = '{11, 10, 10, 10};
    do_reset();
    c = cyc; ENABLE = 1'b1; e0 = c + 5;
    // Edges on terminal cycles e0+100/e0+200, a first-cycle edge at e0+301.
    for (int i = 0; i <= 20; i++) sched.push_back(e0 + 10 * i);
    for (int j = 0; j <= 9; j++) sched.push_back(e0 + 205 + 10 * j);
    for (int j = 0; j <= 9; j++) sched.push_back(e0 + 301 + 10 * j);
    for (int k = 1; k <= 4; k++) begin
      wait_cyc(e0 + 100 * k + 1);
      checks++;
      if (fps.FPS_VALID !== 1'b1 || fps.FPS_VALUE !== 8'(exp_val[k-1])) begin
        errors++;
        $display("FAIL boundary_w%0d: got valid=%b value=%0d want 1/%0d",
                 k, fps.FPS_VALID, fps.FPS_VALUE, exp_val[k-1]);
      end
    end
  endtask

  task automatic test_saturation();
    int c, e0;
    do_reset();
    c = cyc; ENABLE = 1'b1; e0 = c + 5;
    for (int i = 0; i <= 50; i++) sched.push_back(e0 + 4 * i);
    wait_cyc(e0 + 101);
    checks++;
    if (fps_s.FPS_VALUE !== 4'd15 || fps_s.FPS_OVF !== 1'b1) begin
      errors++;
      $display("FAIL sat_w1: got value=%0d ovf=%b want 15/1", fps_s.FPS_VALUE, fps_s.FPS_OVF);
    end
    checks++;
    if (fps.FPS_VALUE !== 8'd26 || fps.FPS_OVF !== 1'b0) begin
      errors++;
      $display("FAIL wide_w1: got value=%0d ovf=%b want 26/0", fps.FPS_VALUE, fps.FPS_OVF);
    end
    wait_cyc(e0 + 201);
    checks++;
    if (fps_s.FPS_VALUE !== 4'd15 || fps_s.FPS_OVF !== 1'b1 || fps_s.FPS_VALID !== 1'b1) begin
      errors++;
      $display("FAIL sat_w2: got value=%0d ovf=%b valid=%b want 15/1/1",
               fps_s.FPS_VALUE, fps_s.FPS_OVF, fps_s.FPS_VALID);
    end
    checks++;
    if (fps.FPS_VALUE !== 8'd25 || fps.FPS_OVF !== 1'b0) begin
      errors++;
      $display("FAIL wide_w2: got value=%0d ovf=%b want 25/0", fps.FPS_VALUE, fps.FPS_OVF);
    end
  endtask

  task automatic test_backpressure();
    int c, e0, bad, drops;
    do_reset();
    fps.FPS_READY = 1'b0;
    c = cyc; ENABLE = 1'b1; e0 = c + 5;
    for (int i = 0; i <= 10; i++) sched.push_back(e0 + 10 * i);
    for (int i = 1; i <= 5; i++) sched.push_back(e0 + 100 + 20 * i);
    wait_cyc(e0 + 101);
    checks++;
    if (fps.FPS_VALID !== 1'b1 || fps.FPS_VALUE !== 8'd11 || fps.FPS_DROP !== 1'b0) begin
      errors++;
      $display("FAIL bp_first: got valid=%b value=%0d drop=%b want 1/11/0",
               fps.FPS_VALID, fps.FPS_VALUE, fps.FPS_DROP);
    end
    bad = 0; drops = 0;
    for (int t = e0 + 102; t <= e0 + 200; t++) begin
      wait_cyc(t);
      if (fps.FPS_VALID !== 1'b1 || fps.FPS_VALUE !== 8'd11) bad++;
      if (fps.FPS_DROP === 1'b1) drops++;
    end
    checks++;
    if (bad != 0 || drops != 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d unstable cycles, %0d drops want 0/0", bad, drops);
    end
    wait_cyc(e0 + 201);
    checks++;
    if (fps.FPS_VALID !== 1'b1 || fps.FPS_VALUE !== 8'd5 || fps.FPS_DROP !== 1'b1) begin
      errors++;
      $display("FAIL bp_overwrite: got valid=%b value=%0d drop=%b want 1/5/1",
               fps.FPS_VALID, fps.FPS_VALUE, fps.FPS_DROP);
    end
    wait_cyc(e0 + 202);
    checks++;
    if (fps.FPS_DROP !== 1'b0 || fps.FPS_VALUE !== 8'd5) begin
      errors++;
      $display("FAIL bp_drop_width: got drop=%b value=%0d want 0/5", fps.FPS_DROP, fps.FPS_VALUE);
    end
    wait_cyc(e0 + 210);
    fps.FPS_READY = 1'b1;
    checks++;
    if (fps.FPS_VALID !== 1'b1) begin
      errors++;
      $display("FAIL bp_xfer_valid: got %b want 1", fps.FPS_VALID);
    end
    wait_cyc(e0 + 211);
    checks++;
    if (fps.FPS_VALID !== 1'b0 || fps.FPS_VALUE !== 8'd5) begin
      errors++;
      $display("FAIL bp_after_xfer: got valid=%b value=%0d want 0/5", fps.FPS_VALID, fps.FPS_VALUE);
    end
  endtask

  task automatic test_enable_toggle();
    int c, e0, e1, nvld;
    do_reset();
    fps.FPS_READY = 1'b0;
    c = cyc; ENABLE = 1'b1; e0 = c + 5;
    for (int i = 0; i <= 20; i++) sched.push_back(e0 + 10 * i);
    wait_cyc(e0 + 130);
    ENABLE = 1'b0;
    sched.delete();
    wait_cyc(e0 + 131);
    checks++;
    if (fps.FPS_VALID !== 1'b0 || fps.FPS_VALUE !== 8'd11 || blink !== 1'b1) begin
      errors++;
      $display("FAIL en_off: got valid=%b value=%0d blink=%b want 0/11/1", fps.FPS_VALID, fps.FPS_VALUE, blink);
    end
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL en_off_state: got %0d want %0d", dut.state_q, IDLE);
    end
    nvld = 0;
    for (int t = e0 + 132; t <= e0 + 260; t++) begin
      wait_cyc(t);
      if (fps.FPS_VALID === 1'b1) nvld++;
    end
    checks++;
    if (nvld != 0) begin
      errors++;
      $display("FAIL en_off_no_result: got %0d valid cycles want 0", nvld);
    end
    ENABLE = 1'b1;
    e1 = cyc + 10;
    for (int i = 0; i <= 9; i++) sched.push_back(e1 + 10 * i);
    wait_cyc(e1 + 100);
    checks++;
    if (fps.FPS_VALID !== 1'b0) begin
      errors++;
      $display("FAIL en_early: got valid=%b want 0", fps.FPS_VALID);
    end
    wait_cyc(e1 + 101);
    checks++;
    if (fps.FPS_VALID !== 1'b1 || fps.FPS_VALUE !== 8'd10 || blink !== 1'b0) begin
      errors++;
      $display("FAIL en_first_result: got valid=%b value=%0d blink=%b want 1/10/0",
               fps.FPS_VALID, fps.FPS_VALUE, blink);
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_boundary();
    test_saturation();
    test_backpressure();
    test_enable_toggle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fps_meter.md
Name: fps_meter

Overview:
Measures display frame rate for FPS test builds. Counts frame-start pulses from the capture/VGA pipeline over fixed one-second windows, timed by an internal clock-cycle counter. Presents each window's result on a valid/ready output to a debug consumer (7-seg driver or UART). Toggles a heartbeat LED at each window boundary.

Parameters:
CLOCKS_PER_SEC, 15998100, clock cycles per measurement window; the terminal count is CLOCKS_PER_SEC-1.
COUNT_W, 8, width of the frame count and result.
SYNC_STAGES, 2, flip-flop stages on FRAME_PULSE; minimum 2.

Ports:
CLK16MHz  in  1  system clock, 16 MHz.
RST_N  in  1  asynchronous active-low reset.
ENABLE  in  1  measurement enable, synchronous to CLK16MHz.
FRAME_PULSE  in  1  frame-start strobe, asynchronous. Each rising edge is one frame.
FPS_VALUE  out  COUNT_W  frames counted in the last completed window.
FPS_OVF  out  1  the frame count saturated in that window.
FPS_VALID  out  1  result is available.
FPS_READY  in  1  consumer accepts the result.
FPS_DROP  out  1  one-cycle pulse when an unaccepted result is overwritten.
BLINK_PIN  out  1  heartbeat. Toggles at every window end.

Behaviour:
- Reset (RST_N low, asynchronous): all outputs are 0. State is IDLE. Window counter, frame counter and synchroniser are cleared.
- FRAME_PULSE passes through SYNC_STAGES flip-flops, then a rising-edge detector. The internal FRAME_EDGE strobe is one cycle wide and appears SYNC_STAGES+1 cycles after the input rises. FRAME_PULSE high-time must be at least 2 cycles.
- The window counter is 32 bits. The frame counter is COUNT_W bits and saturates at 2^COUNT_W-1. It never wraps.
- States:
  - IDLE: counters are held at 0. Go to ALIGN when ENABLE=1.
  - ALIGN: wait for FRAME_EDGE. On that edge: window counter=0, frame count=1, go to MEASURE. This aligns windows to frame boundaries.
  - MEASURE: window counter increments each cycle, and frame count increments on each FRAME_EDGE. On the terminal cycle (window counter == CLOCKS_PER_SEC-1), the result is latched and the next window starts back-to-back: window counter=0 and frame count=0 on the next cycle. There is no dead cycle. Stays in MEASURE.
- An edge on the terminal cycle is counted in the closing window. An edge on the first cycle of a window is counted in the new window.
- Saturation: if the count is at its maximum and another edge arrives, the overflow flag for the window is set. FPS_OVF is latched together with FPS_VALUE.
- Result latch: occurs on the cycle after the terminal cycle. FPS_VALUE, FPS_OVF and FPS_VALID=1 are registered, and BLINK_PIN toggles.
- Handshake: FPS_VALUE and FPS_OVF are stable while FPS_VALID=1 and FPS_READY=0. A transfer occurs when FPS_VALID && FPS_READY, and FPS_VALID drops on the next cycle unless a new latch happens in that same cycle.
- New latch while FPS_VALID=1:
  - If FPS_READY=1 in that cycle, the old result is taken. The new one is loaded, FPS_VALID stays 1, and there is no FPS_DROP.
  - If FPS_READY=0, the new result overwrites the old one and FPS_DROP pulses for 1 cycle.
- ENABLE falling (any state): go to IDLE next cycle. Counters and the synchroniser edge history are cleared, and FPS_VALID is cleared. FPS_VALUE, FPS_OVF and BLINK_PIN hold their values.
- ENABLE rising: always re-enters ALIGN. A partial window is never reported.
- RST_N asserted mid-window: immediate clear. No result is produced for the partial window.

Decomposition:
- Shared package gbvga_pkg holds:
  - CLK_HZ_16M and the calibrated CLOCKS_PER_SEC_CAL = 15998100.
  - The fps_state_t enum (IDLE, ALIGN, MEASURE).
- One sub-module, pulse_sync: a SYNC_STAGES-deep synchroniser plus rising-edge detector with active-low async reset. It will be reused for other asynchronous Game Boy strobes.

Test Plan:
- Reset: with RST_N low mid-MEASURE, all outputs read 0 asynchronously (without waiting for a clock edge). After release with ENABLE=0, the state stays IDLE and no FPS_VALID appears over 1000 cycles.
- Steady rate: CLOCKS_PER_SEC=100, pulses 2 cycles wide every 10 cycles, FPS_READY=1 → FPS_VALUE=10 every 100 cycles, FPS_OVF=0, and BLINK_PIN toggles with each result.
- Boundary: CLOCKS_PER_SEC=100 with an edge forced onto the terminal cycle and onto the following first cycle → that window reports 10 and the next window reports 10, with no double count.
- Saturation: COUNT_W=4, CLOCKS_PER_SEC=100, pulse every 4 cycles (25 edges) → FPS_VALUE=15, FPS_OVF=1.
- Backpressure: FPS_READY=0 across two window ends → first value held stable, FPS_DROP pulses once, FPS_VALUE becomes the second result. Raising FPS_READY then gives one transfer and FPS_VALID drops.
- Enable toggle: ENABLE low 30 cycles into a window → FPS_VALID=0 and no result. Re-enabled, the first result arrives CLOCKS_PER_SEC+1 cycles after the aligning edge.
